// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator result display block.
//   - sign codes produced by the calculator FSM
//   - display FSM state encoding
//   - active-low 7-segment patterns, bit7 = a ... bit1 = g, bit0 = dp
//   - seg_digit(): BCD digit -> segment pattern lookup
package calc_disp_pkg;

    localparam logic [3:0] SIGN_POS = 4'd0;
    localparam logic [3:0] SIGN_NEG = 4'd11;

    // Largest magnitudes that fit in four digits, without and with a minus sign.
    localparam int BCD_LIMIT = 9999;
    localparam int NEG_LIMIT = 999;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'b1111_1101;
    localparam logic [7:0] SEG_E     = 8'b0110_0001;

    function automatic logic [7:0] seg_digit(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : load bin and begin a conversion (takes priority over a running one)
//   bin      : binary value to convert
//   done     : high during the final shift cycle; bcd is valid from the next cycle
//   bcd      : low four BCD digits {d3,d2,d1,d0}
module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int VALUE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] bin,
    output logic               done,
    output logic [15:0]        bcd
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int SHIFT_W = BCD_W + VALUE_W;
    localparam int CNT_W   = (VALUE_W > 2) ? $clog2(VALUE_W) : 1;

    // BCD digits in the upper part, unconsumed binary bits in the lower part.
    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] shift_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               run_reg;
    logic [BCD_W-1:0]   bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shift_reg[VALUE_W + 4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    // The shift discards the carry out of the top digit. Each nibble's
    // correction depends only on itself, so the low four digits stay exact
    // even for values above 9999.
    assign shift_next = {bcd_adj, shift_reg[VALUE_W-1:0]} << 1;

    assign done = run_reg && (cnt_reg == CNT_W'(VALUE_W - 1));
    assign bcd  = shift_reg[VALUE_W +: BCD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
        end else if (start) begin
            shift_reg <= {{BCD_W{1'b0}}, bin};
            cnt_reg   <= '0;
            run_reg   <= 1'b1;
        end else if (run_reg) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + 1'b1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Display-side consumer of the calculator FSM result.
// Detects changes of {sign,value}, converts the magnitude to BCD one bit per
// clock, then drives a 4-digit multiplexed active-low 7-segment display with
// leading-zero blanking, a minus sign and an all-'E' overflow pattern.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   value    : binary magnitude of the result
//   sign     : 0 = positive, 11 = negative, other codes treated as positive
//   busy     : conversion in progress
//   bcd      : committed BCD digits {d3,d2,d1,d0}
//   ovf      : committed result does not fit in four digits
//   ssd_ctl  : active-low one-hot digit enables, bit0 = rightmost digit
//   segs     : active-low segments, bit7 = a ... bit1 = g, bit0 = dp (off)
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV = 17,
    parameter int VALUE_W  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic [3:0]         sign,
    output logic               busy,
    output logic [15:0]        bcd,
    output logic               ovf,
    output logic [3:0]         ssd_ctl,
    output logic [7:0]         segs
);

    // ------------------------------------------------------------------
    // Capture / conversion control
    // ------------------------------------------------------------------
    state_t               state_reg;
    state_t               state_next;
    logic [VALUE_W-1:0]   shadow_value_reg;
    logic [3:0]           shadow_sign_reg;
    logic                 busy_reg;
    logic [15:0]          bcd_reg;
    logic                 ovf_reg;
    logic                 minus_reg;

    logic                 input_changed;
    logic                 conv_start;
    logic                 conv_done;
    logic [15:0]          conv_bcd;

    logic                 shadow_neg;
    logic [31:0]          shadow_mag;
    logic                 commit_ovf;
    logic                 commit_minus;

    assign input_changed = ({sign, value} != {shadow_sign_reg, shadow_value_reg});

    bin2bcd_seq #(
        .VALUE_W (VALUE_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (input_changed) begin
                    conv_start = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Overflow and minus decisions come from the shadow, which is exactly the
    // value that was converted; the live input may already have moved on.
    assign shadow_neg   = (shadow_sign_reg == SIGN_NEG);
    assign shadow_mag   = 32'(shadow_value_reg);
    assign commit_ovf   = (shadow_mag > 32'(BCD_LIMIT)) ||
                          (shadow_neg && (shadow_mag > 32'(NEG_LIMIT)));
    // Negative zero is displayed as plain zero.
    assign commit_minus = shadow_neg && (shadow_mag != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            shadow_value_reg <= '0;
            shadow_sign_reg  <= '0;
            busy_reg         <= 1'b0;
            bcd_reg          <= '0;
            ovf_reg          <= 1'b0;
            minus_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (conv_start) begin
                shadow_value_reg <= value;
                shadow_sign_reg  <= sign;
                busy_reg         <= 1'b1;
            end
            if (state_reg == COMMIT) begin
                bcd_reg   <= conv_bcd;
                ovf_reg   <= commit_ovf;
                minus_reg <= commit_minus;
                busy_reg  <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;
    assign bcd  = bcd_reg;
    assign ovf  = ovf_reg;

    // ------------------------------------------------------------------
    // Digit rendering (from committed state only)
    // ------------------------------------------------------------------
    logic [7:0] digit_seg [NUM_DIGITS];
    logic [3:0] lead_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_render
            logic [3:0] nib;
            assign nib = bcd_reg[4*gi +: 4];
            // This digit and every digit to its left are zero.
            assign lead_zero[gi] = (bcd_reg[15:4*gi] == '0);
            assign digit_seg[gi] = ovf_reg                      ? SEG_E     :
                                   ((gi == 3) && minus_reg)     ? SEG_MINUS :
                                   ((gi != 0) && lead_zero[gi]) ? SEG_BLANK :
                                                                  seg_digit(nib);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan: enables and segments registered from the same index so the
    // pattern and the digit it belongs to always change on the same edge.
    // ------------------------------------------------------------------
    logic [SCAN_DIV-1:0] scan_cnt_reg;
    logic [1:0]          scan_idx;
    logic [3:0]          ssd_ctl_reg;
    logic [7:0]          segs_reg;

    assign scan_idx = scan_cnt_reg[SCAN_DIV-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            ssd_ctl_reg  <= 4'b1110;
            segs_reg     <= SEG_0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
            ssd_ctl_reg  <= ~(4'b0001 << scan_idx);
            segs_reg     <= digit_seg[scan_idx];
        end
    end

    assign ssd_ctl = ssd_ctl_reg;
    assign segs    = segs_reg;

endmodule

// File: tb/tb_calc_result_display.sv
module tb_calc_result_display;

    localparam int SCAN_DIV    = 6;
    localparam int SCAN_CYCLES = 1 << SCAN_DIV;
    localparam int DWELL       = 1 << (SCAN_DIV - 2);

    localparam logic [7:0] T_BLANK = 8'hFF;
    localparam logic [7:0] T_MINUS = 8'b1111_1101;
    localparam logic [7:0] T_E     = 8'b0110_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    logic [3:0]  sign = '0;
    logic        busy;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  ssd_ctl;
    logic [7:0]  segs;

    int n_checks = 0;
    int n_passed = 0;
    logic [15:0] committed_bcd = '0;

    calc_result_display #(
        .SCAN_DIV (SCAN_DIV),
        .VALUE_W  (14)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .sign    (sign),
        .busy    (busy),
        .bcd     (bcd),
        .ovf     (ovf),
        .ssd_ctl (ssd_ctl),
        .segs    (segs)
    );

    always #5 clk = ~clk;

    // Standard active-low patterns, segment order a b c d e f g dp.
    function automatic logic [7:0] tseg(input int d);
        case (d)
            0: return 8'b0000_0011;
            1: return 8'b1001_1111;
            2: return 8'b0010_0101;
            3: return 8'b0000_1101;
            4: return 8'b1001_1001;
            5: return 8'b0100_1001;
            6: return 8'b0100_0001;
            7: return 8'b0001_1111;
            8: return 8'b0000_0001;
            9: return 8'b0000_1001;
            default: return T_BLANK;
        endcase
    endfunction

    // Reference model: decimal arithmetic on the magnitude.
    function automatic logic [15:0] m_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic m_ovf(input int v, input logic [3:0] s);
        return (v > 9999) || (s == 4'd11 && v > 999);
    endfunction

    function automatic logic [31:0] m_segs(input int v, input logic [3:0] s);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (m_ovf(v, s))
                r[8*i +: 8] = T_E;
            else if (i == 3 && s == 4'd11 && v != 0)
                r[8*i +: 8] = T_MINUS;
            else if (i > 0 && v < p)
                r[8*i +: 8] = T_BLANK;
            else
                r[8*i +: 8] = tseg(v / p % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_passed++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Observe one full scan period; every digit must be enabled DWELL cycles,
    // show its expected pattern, and busy must stay low.
    task automatic scan_check(input string tag, input logic [31:0] exp_segs);
        int cnt [4];
        logic [7:0] seen [4];
        int bad_onehot;
        int busy_high;
        int idx;
        bad_onehot = 0;
        busy_high = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            seen[i] = 8'h00;
        end
        @(posedge clk);
        for (int c = 0; c < SCAN_CYCLES; c++) begin
            @(negedge clk);
            idx = -1;
            case (ssd_ctl)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: bad_onehot++;
            endcase
            if (idx >= 0) begin
                cnt[idx]++;
                if (cnt[idx] == 1 || segs !== seen[idx]) begin
                    if (cnt[idx] > 1) seen[idx] = 8'h00; // inconsistent within dwell
                    else seen[idx] = segs;
                end
            end
            if (busy) busy_high++;
        end
        check({tag, " onehot_errors"}, 32'(bad_onehot), 32'd0);
        check({tag, " busy_while_idle"}, 32'(busy_high), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s digit%0d_dwell", tag, i), 32'(cnt[i]), 32'(DWELL));
            check($sformatf("%s digit%0d_segs", tag, i), 32'(seen[i]), 32'(exp_segs[8*i +: 8]));
        end
    endtask

    // Apply a new input and check busy duration, commit latency and display.
    task automatic apply(input string tag, input logic [13:0] v, input logic [3:0] s,
                         input logic [15:0] exp_bcd, input logic exp_ovf,
                         input logic [31:0] exp_segs);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        value = v;
        sign = s;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k <= 15 && busy) busy_cnt++;
            if (k == 15) check({tag, " bcd_before_commit"}, 32'(bcd), 32'(committed_bcd));
            if (k == 16) begin
                check({tag, " busy_after_commit"}, 32'(busy), 32'd0);
                check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
                check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
            end
        end
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd15);
        committed_bcd = exp_bcd;
        $display("txn %s: value=%0d sign=%0d bcd=%h ovf=%0b", tag, v, s, bcd, ovf);
        scan_check(tag, exp_segs);
    endtask

    typedef struct {
        logic [13:0] value;
        logic [3:0]  sign;
        logic [15:0] bcd;
        logic        ovf;
        logic [31:0] segs;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [13:0] cur_v;
        logic [3:0]  cur_s;
        logic [13:0] rv;
        logic [3:0]  rs;

        vecs[0] = '{14'd9801,  4'd0,  16'h9801, 1'b0, {tseg(9), tseg(8), tseg(0), tseg(1)}};
        vecs[1] = '{14'd37,    4'd11, 16'h0037, 1'b0, {T_MINUS, T_BLANK, tseg(3), tseg(7)}};
        vecs[2] = '{14'd10000, 4'd0,  16'h0000, 1'b1, {T_E, T_E, T_E, T_E}};
        vecs[3] = '{14'd1200,  4'd11, 16'h1200, 1'b1, {T_E, T_E, T_E, T_E}};
        vecs[4] = '{14'd0,     4'd11, 16'h0000, 1'b0, {T_BLANK, T_BLANK, T_BLANK, tseg(0)}};
        vecs[5] = '{14'd999,   4'd11, 16'h0999, 1'b0, {T_MINUS, tseg(9), tseg(9), tseg(9)}};
        vecs[6] = '{14'd9999,  4'd0,  16'h9999, 1'b0, {tseg(9), tseg(9), tseg(9), tseg(9)}};
        vecs[7] = '{14'd100,   4'd5,  16'h0100, 1'b0, {T_BLANK, tseg(1), tseg(0), tseg(0)}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset ssd_ctl", 32'(ssd_ctl), 32'b1110);
        check("reset segs", 32'(segs), 32'(tseg(0)));
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset: bcd=%h ssd_ctl=%b segs=%b", bcd, ssd_ctl, segs);
        scan_check("idle_after_reset", {T_BLANK, T_BLANK, T_BLANK, tseg(0)});

        // Table vectors
        for (int i = 0; i < 8; i++)
            apply($sformatf("vec%0d", i), vecs[i].value, vecs[i].sign,
                  vecs[i].bcd, vecs[i].ovf, vecs[i].segs);

        // Input change during CONV: 5, then 6 in the third CONV cycle
        @(negedge clk);
        value = 14'd5;
        sign = 4'd0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("mid_conv busy_start", 32'(busy), 32'd1);
            if (k == 3) value = 14'd6;
            if (k == 16) begin
                check("mid_conv first_bcd", 32'(bcd), 32'h0005);
                check("mid_conv first_busy", 32'(busy), 32'd0);
            end
            if (k == 17) check("mid_conv second_start", 32'(busy), 32'd1);
            if (k == 31) check("mid_conv second_busy", 32'(busy), 32'd1);
            if (k == 32) begin
                check("mid_conv second_bcd", 32'(bcd), 32'h0006);
                check("mid_conv second_done", 32'(busy), 32'd0);
            end
        end
        $display("txn mid_conv: value=5->6 bcd=%h", bcd);
        scan_check("mid_conv", {T_BLANK, T_BLANK, T_BLANK, tseg(6)});

        // Reset during the seventh CONV cycle
        @(negedge clk);
        value = 14'd4321;
        sign = 4'd0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("rst_conv busy_start", 32'(busy), 32'd1);
            if (k == 7) rst = 1'b1;
            if (k == 8) begin
                check("rst_conv bcd", 32'(bcd), 32'd0);
                check("rst_conv busy", 32'(busy), 32'd0);
                check("rst_conv ssd_ctl", 32'(ssd_ctl), 32'b1110);
                check("rst_conv segs", 32'(segs), 32'(tseg(0)));
                rst = 1'b0;
            end
            if (k == 9) check("rst_conv restart", 32'(busy), 32'd1);
            if (k == 23) check("rst_conv busy_hold", 32'(busy), 32'd1);
            if (k == 24) begin
                check("rst_conv final_bcd", 32'(bcd), 32'h4321);
                check("rst_conv final_busy", 32'(busy), 32'd0);
            end
        end
        committed_bcd = 16'h4321;
        $display("txn rst_conv: value=4321 bcd=%h", bcd);
        scan_check("rst_conv", {tseg(4), tseg(3), tseg(2), tseg(1)});

        // Randomized against the reference model
        cur_v = 14'd4321;
        cur_s = 4'd0;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0: rv = 14'($urandom_range(0, 9));
                1: rv = 14'($urandom_range(990, 1010));
                2: rv = 14'($urandom_range(9990, 10010));
                3: rv = 14'($urandom_range(0, 16383));
                default: rv = 14'($urandom_range(0, 9999));
            endcase
            case ($urandom_range(0, 3))
                0: rs = 4'd0;
                1, 2: rs = 4'd11;
                default: rs = 4'($urandom_range(0, 15));
            endcase
            if (rv == cur_v && rs == cur_s) rv = rv ^ 14'd1;
            apply($sformatf("rand%0d", i), rv, rs, m_bcd(int'(rv)),
                  m_ovf(int'(rv), rs), m_segs(int'(rv), rs));
            cur_v = rv;
            cur_s = rs;
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Display-side consumer of the keypad calculator FSM's result outputs, `value[13:0]` and `sign[3:0]`.
- Watches the result for changes and converts the binary value to 4-digit BCD sequentially (shift-add-3, one bit per clock).
- Drives the 4-digit active-low 7-segment display with time-multiplexed scanning, leading-zero blanking, a minus sign and an overflow pattern.

Parameters:
- SCAN_DIV, 17, width of the free-running refresh counter; its top 2 bits select the active digit.
- VALUE_W, 14, width of the binary result input.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value  input  VALUE_W  binary magnitude of the result from the calculator FSM
- sign  input  4  0 = positive, 11 = negative; any other code is treated as positive
- busy  output  1  high while a conversion is in progress
- bcd  output  16  committed BCD digits {d3,d2,d1,d0}
- ovf  output  1  committed result cannot be shown in 4 digits
- ssd_ctl  output  4  digit enables, active-low one-hot; bit0 = rightmost digit
- segs  output  8  active-low segments, bit7 = a ... bit1 = g, bit0 = dp (dp always off)

Behaviour:
- Reset values:
  - shadow {sign,value} = 0, bcd = 0, ovf = 0, busy = 0, scan counter = 0.
  - ssd_ctl = 4'b1110; segs = SEG_0 on digit0; display reads "   0".
- State machine IDLE -> CONV -> COMMIT -> IDLE.
- IDLE: each cycle compare {sign,value} against the shadow.
  - If they differ, latch the input into the shadow, load the shift register, set busy, go to CONV.
  - If they are equal, stay in IDLE.
- CONV: exactly VALUE_W cycles.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift left 1, bringing in the next binary MSB.
  - A 4-bit bit counter ends the state.
- COMMIT: 1 cycle.
  - Update bcd and ovf together; clear busy; return to IDLE.
  - bcd/ovf only ever change in COMMIT.
- Latency: change present at edge N -> bcd valid after edge N+VALUE_W+2 (N+16 for defaults); busy high for VALUE_W+1 cycles.
- Input changes during CONV/COMMIT are ignored. The shadow compare in the next IDLE cycle picks up the latest value, so no update is lost; intermediate values are skipped.
- ovf = 1 in either case:
  - shadow value > 9999;
  - shadow negative and value > 999 (the minus sign needs digit3).
- When ovf = 1, bcd holds the low 4 BCD digits and all four digits show SEG_E.
- Digit rendering for d3..d1:
  - blank when the digit and all digits to its left are 0;
  - d0 is never blanked.
- Negative results: digit3 shows SEG_MINUS and overrides d3 (always 0 here), whatever the blanking.
- Negative zero (sign = 11, value = 0) shows "   0"; the minus is suppressed.
- Scan:
  - The counter free-runs, including during CONV.
  - Digit index = counter[SCAN_DIV-1:SCAN_DIV-2]; 0 = rightmost.
  - ssd_ctl and segs are registered together from the same index, so there is no ghosting.
  - During CONV the display keeps showing the last committed bcd/ovf.
- Reset asserted mid-conversion aborts to IDLE with all reset values. The next cycle re-detects a nonzero input against the zeroed shadow and converts it.
- Sign codes other than 0/11 are treated as positive.

Decomposition:
- Package calc_disp_pkg holds:
  - SIGN_POS = 4'd0, SIGN_NEG = 4'd11;
  - state encodings IDLE/CONV/COMMIT;
  - segment constants SEG_0..SEG_9 (SEG_0 = 8'b0000_0011), SEG_BLANK = 8'hFF, SEG_MINUS = 8'b1111_1101, SEG_E = 8'b0110_0001.
- One sub-module, bin2bcd_seq: the shift-add-3 datapath plus bit counter with a start/done interface.
- Capture, render and scan logic stay in the top level.

Test Plan:
- Reset, then value = 9801, sign = 0 -> busy high 15 cycles, bcd = 16'h9801 at edge +16, ovf = 0; scan shows 9,8,0,1 on ssd_ctl 0111,1011,1101,1110.
- value = 37, sign = 11 -> bcd = 16'h0037; digits "- 37": digit3 SEG_MINUS, digit2 SEG_BLANK, digit1 SEG_3, digit0 SEG_7.
- value = 5, then value = 6 on the 3rd cycle of CONV -> first commit bcd = 16'h0005, then a second conversion starting the cycle after COMMIT gives bcd = 16'h0006.
- value = 10000 -> ovf = 1, all digits SEG_E. Then value = 1200, sign = 11 -> ovf = 1. Then value = 0, sign = 11 -> "   0", ovf = 0.
- value = 4321; assert rst during the 7th CONV cycle -> next cycle bcd = 0, busy = 0, ssd_ctl = 1110. After rst drops, a new conversion starts and commits bcd = 16'h4321.
- Hold input constant for 2^SCAN_DIV cycles -> busy stays 0, each digit enabled exactly 2^(SCAN_DIV-2) cycles, ssd_ctl always one-hot low.
